// File: rtl/axi_pkg.sv
// Shared AXI write-address types for the AW arbiter slice.
// AXI_ADDR_W is the default address width; the arbiter's ADDR_WIDTH
// parameter defaults to it.
package axi_pkg;

    localparam int         AXI_ADDR_W     = 12;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Requester index: 0 or 1.
    typedef logic axi_id_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } aw_req_t;

    typedef enum logic {
        AW_IDLE = 1'b0,
        AW_HOLD = 1'b1
    } aw_state_t;

endpackage

// File: rtl/order_fifo.sv
// Small synchronous FIFO holding the grant order.
// The head entry is read straight from the storage array at the read pointer.
// Pops while empty and pushes while full are ignored.
// Pointers wrap naturally; the count is one bit wider than the pointers so
// that full and empty can be told apart.
module order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared on reset so the
    // head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_aw_arbiter.sv
// Two-port AW arbiter in front of a single address counter. One AW is held
// on the registered m_aw* outputs at a time; the requester index of every
// grant is queued so W-channel steering can follow AW order.
// Optional feature macro: AWARB_RR_EN (round-robin on ties; otherwise
// requester 0 has fixed priority).
//
//   state   | meaning
//   --------+-------------------------------------------------
//   AW_IDLE | no AW presented; a grant may happen this cycle
//   AW_HOLD | m_awvalid=1, m_aw* fields held until m_awready
module axi_aw_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH  = AXI_ADDR_W,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s0_awaddr,
    input  logic [7:0]            s0_awlen,
    input  logic [2:0]            s0_awsize,
    input  logic [1:0]            s0_awburst,
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [ADDR_WIDTH-1:0] s1_awaddr,
    input  logic [7:0]            s1_awlen,
    input  logic [2:0]            s1_awsize,
    input  logic [1:0]            s1_awburst,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic                  w_sel_data,
    output logic                  w_sel_valid,
    input  logic                  w_sel_ready
);

    aw_state_t state;
    axi_id_t   grant_id;
    logic      grant;
    logic      fifo_empty;
    logic      fifo_full;

`ifdef AWARB_RR_EN
    axi_id_t last_grant;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        grant_id = 1'b0;
        if (s0_awvalid && s1_awvalid) begin
            grant_id = ~last_grant;
        end else if (s1_awvalid) begin
            grant_id = 1'b1;
        end
    end

    // Remember the last winner; reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant) begin
            last_grant <= grant_id;
        end
    end
`else
    // Fixed priority pick: requester 0 wins whenever it is valid.
    always_comb begin
        grant_id = 1'b0;
        if (!s0_awvalid) begin
            grant_id = 1'b1;
        end
    end
`endif

    // Full is the registered count, so a pop in this cycle cannot unblock
    // a grant in the same cycle.
    assign grant      = !reset && (state == AW_IDLE) && !fifo_full
                        && (s0_awvalid || s1_awvalid);
    assign s0_awready = grant && (grant_id == 1'b0);
    assign s1_awready = grant && (grant_id == 1'b1);

    // AW FSM: latch the winner's fields on grant, hold them until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= AW_IDLE;
            m_awvalid <= 1'b0;
            m_awaddr  <= '0;
            m_awlen   <= '0;
            m_awsize  <= '0;
            m_awburst <= '0;
        end else begin
            case (state)
                AW_IDLE: begin
                    if (grant) begin
                        state     <= AW_HOLD;
                        m_awvalid <= 1'b1;
                        if (grant_id) begin
                            m_awaddr  <= s1_awaddr;
                            m_awlen   <= s1_awlen;
                            m_awsize  <= s1_awsize;
                            m_awburst <= s1_awburst;
                        end else begin
                            m_awaddr  <= s0_awaddr;
                            m_awlen   <= s0_awlen;
                            m_awsize  <= s0_awsize;
                            m_awburst <= s0_awburst;
                        end
                    end
                end
                AW_HOLD: begin
                    if (m_awready) begin
                        state     <= AW_IDLE;
                        m_awvalid <= 1'b0;
                    end
                end
                default: begin
                    state     <= AW_IDLE;
                    m_awvalid <= 1'b0;
                end
            endcase
        end
    end

    order_fifo #(
        .WIDTH (1),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .push_data (grant_id),
        .pop       (w_sel_ready),
        .head      (w_sel_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign w_sel_valid = !fifo_empty;

endmodule
